// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among NUM_MASTERS masters.
// One master owns the bus per tenure; a watchdog aborts a tenure whose slave never acks.
module wishbone_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_data_o,
  input  logic [DATA_W-1:0]             s_data_i,
  input  logic                          s_ack_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          busy_o
);

  localparam int LW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [LW-1:0]   LAST_RST = LW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic          found;
  logic [LW-1:0] pick;
  logic          owner_cyc, owner_stb, stall;

  // last_q doubles as the owner index while a tenure is active
  assign owner_cyc = m_cyc_i[last_q];
  assign owner_stb = m_stb_i[last_q];
  assign stall     = owner_stb & ~s_ack_i;

  // Scan requesters starting just after the previous winner
  always_comb begin
    logic [LW-1:0] idx;
    found = 1'b0;
    pick  = last_q;
    idx   = last_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (idx == LAST_RST) ? '0 : idx + 1'b1;
      if (!found && m_cyc_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = '0;
    m_err_o = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = GRANT;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
        end
      end
      GRANT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (stall && (TIMEOUT_CYCLES != 0)) begin
          // This cycle is the TIMEOUT_CYCLES-th unacked strobe; an ack here would win
          if (wd_q == WD_LAST) begin
            m_err_o[last_q] = 1'b1;
            state_d         = ABORT;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  // Slave-side mux is purely combinational so reset drops s_cyc_o without a clock
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    m_ack_o  = '0;
    if (state_q == GRANT) begin
      s_cyc_o         = owner_cyc;
      s_stb_o         = owner_stb;
      s_we_o          = m_we_i[last_q];
      s_addr_o        = m_addr_i[last_q*ADDR_W +: ADDR_W];
      s_data_o        = m_data_i[last_q*DATA_W +: DATA_W];
      m_ack_o[last_q] = s_ack_i & owner_stb;
    end
  end

  assign m_data_o = s_data_i;
  assign grant_o  = grant_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Bench for wishbone_rr_arbiter: two masters, 8-cycle watchdog, scoreboard of expected grants.
module tb_wishbone_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_data_i;
  logic [DW-1:0]   m_data_o;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_data_o;
  logic [DW-1:0]   s_data_i;
  logic            s_ack_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  wishbone_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic set_m(input logic idx, input logic cyc, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cyc_i[idx]            = cyc;
    m_stb_i[idx]            = cyc;
    m_we_i[idx]             = we;
    m_addr_i[idx*AW +: AW]  = a;
    m_data_i[idx*DW +: DW]  = d;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    do begin
      @(posedge clk_i); #1;
      waited++;
    end while (grant_o == '0 && waited < 20);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_addr_i = '0; m_data_i = '0; s_data_i = '0; s_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b want 00", grant_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin n_err++; $display("FAIL rst_scyc: got %b%b want 00", s_cyc_o, s_stb_o); end
    n_cmp++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin n_err++; $display("FAIL rst_ackerr: got %b/%b want 00/00", m_ack_o, m_err_o); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL rst_idle_grant: got %b want 00", grant_o); end
  endtask

  // Both masters request together: m0 first, m1 after one idle cycle
  task automatic test_arbitration();
    int   waited;
    exp_t e;
    logic owner;
    exp_q.push_back('{grant: 2'b01, addr: 16'h1000, data: 16'hA0A0});
    exp_q.push_back('{grant: 2'b10, addr: 16'h2000, data: 16'hB1B1});
    set_m(1'b0, 1'b1, 1'b1, 16'h1000, 16'hA0A0);
    set_m(1'b1, 1'b1, 1'b1, 16'h2000, 16'hB1B1);
    for (int t = 0; t < 2; t++) begin
      wait_grant(waited);
      e = exp_q.pop_front();
      owner = e.grant[1];
      n_cmp++; if (waited !== 1) begin n_err++; $display("FAIL arb_latency%0d: got %0d want 1", t, waited); end
      n_cmp++; if (grant_o !== e.grant) begin n_err++; $display("FAIL arb_grant%0d: got %b want %b", t, grant_o, e.grant); end
      n_cmp++; if (s_addr_o !== e.addr || s_data_o !== e.data || s_we_o !== 1'b1)
        begin n_err++; $display("FAIL arb_mux%0d: got %h/%h/%b want %h/%h/1", t, s_addr_o, s_data_o, s_we_o, e.addr, e.data); end
      s_ack_i = 1'b1; s_data_i = 16'h5A00 + 16'(t);
      #1;
      n_cmp++; if (m_ack_o !== e.grant) begin n_err++; $display("FAIL arb_ack%0d: got %b want %b", t, m_ack_o, e.grant); end
      n_cmp++; if (m_data_o !== 16'h5A00 + 16'(t)) begin n_err++; $display("FAIL arb_rdata%0d: got %h want %h", t, m_data_o, 16'h5A00 + 16'(t)); end
      @(posedge clk_i); #1;
      s_ack_i = 1'b0;
      set_m(owner, 1'b0, 1'b0, '0, '0);
      @(posedge clk_i); #1;
      n_cmp++; if (grant_o !== 2'b00 || busy_o !== 1'b0) begin n_err++; $display("FAIL arb_gap%0d: got %b/%b want 00/0", t, grant_o, busy_o); end
    end
  endtask

  // Both keep requesting; each owner drops cyc for one cycle after its ack
  task automatic test_round_robin();
    int   waited;
    exp_t e;
    logic owner;
    for (int t = 0; t < 4; t++) exp_q.push_back('{grant: (t % 2 == 0) ? 2'b01 : 2'b10, addr: 16'(t), data: '0});
    set_m(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0);
    set_m(1'b1, 1'b1, 1'b0, 16'h0301, 16'h0);
    for (int t = 0; t < 4; t++) begin
      wait_grant(waited);
      e = exp_q.pop_front();
      owner = e.grant[1];
      n_cmp++; if (grant_o !== e.grant || waited !== 1)
        begin n_err++; $display("FAIL rr_grant%0d: got %b after %0d want %b after 1", t, grant_o, waited, e.grant); end
      s_ack_i = 1'b1;
      #1;
      n_cmp++; if (m_ack_o !== e.grant) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", t, m_ack_o, e.grant); end
      @(posedge clk_i); #1;
      s_ack_i = 1'b0;
      set_m(owner, 1'b0, 1'b0, '0, '0);
      @(posedge clk_i); #1;
      if (t < 3) set_m(owner, 1'b1, 1'b0, 16'h0300 + 16'(owner), '0);
      else begin m_cyc_i = '0; m_stb_i = '0; end
    end
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rr_end_busy: got %b want 0", busy_o); end
  endtask

  // Slave never acks: err pulses on the 8th strobe cycle, then ABORT until cyc drops
  task automatic test_timeout();
    int waited;
    int pulses = 0;
    int errcyc = 0;
    set_m(1'b0, 1'b1, 1'b0, 16'h0400, '0);
    wait_grant(waited);
    n_cmp++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL to_grant: got %b want 01", grant_o); end
    for (int c = 1; c <= 12; c++) begin
      if (m_err_o !== 2'b00) begin
        pulses++; errcyc = c;
        n_cmp++; if (m_err_o !== 2'b01) begin n_err++; $display("FAIL to_err_bit: got %b want 01", m_err_o); end
      end
      if (c == 9) begin
        n_cmp++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b01 || busy_o !== 1'b1)
          begin n_err++; $display("FAIL to_abort: got cyc%b stb%b g%b b%b want 0 0 01 1", s_cyc_o, s_stb_o, grant_o, busy_o); end
        s_ack_i = 1'b1;
        #1;
        n_cmp++; if (m_ack_o !== 2'b00) begin n_err++; $display("FAIL to_late_ack: got %b want 00", m_ack_o); end
      end
      if (c == 10) set_m(1'b0, 1'b0, 1'b0, '0, '0);
      if (c == 11) begin
        n_cmp++; if (grant_o !== 2'b00 || busy_o !== 1'b0) begin n_err++; $display("FAIL to_release: got %b/%b want 00/0", grant_o, busy_o); end
      end
      @(posedge clk_i); #1;
      s_ack_i = 1'b0;
      #1;
    end
    n_cmp++; if (pulses !== 1 || errcyc !== TO)
      begin n_err++; $display("FAIL to_err_pulse: got %0d pulses at cycle %0d want 1 at %0d", pulses, errcyc, TO); end
  endtask

  // Ack arrives exactly on the timeout cycle: delivered, no err, counter restarts
  task automatic test_ack_at_timeout();
    int waited;
    int firsterr = 0;
    set_m(1'b1, 1'b1, 1'b1, 16'h0500, 16'h0055);
    wait_grant(waited);
    n_cmp++; if (grant_o !== 2'b10) begin n_err++; $display("FAIL at_grant: got %b want 10", grant_o); end
    for (int c = 1; c <= 16; c++) begin
      if (c == TO) begin
        s_ack_i = 1'b1;
        #1;
        n_cmp++; if (m_ack_o !== 2'b10 || m_err_o !== 2'b00)
          begin n_err++; $display("FAIL at_ack_wins: got ack%b err%b want 10/00", m_ack_o, m_err_o); end
      end else if (m_err_o !== 2'b00 && firsterr == 0) firsterr = c;
      if (c == TO + 1) begin
        n_cmp++; if (s_cyc_o !== 1'b1 || busy_o !== 1'b1) begin n_err++; $display("FAIL at_still_grant: got cyc%b busy%b want 1 1", s_cyc_o, busy_o); end
      end
      @(posedge clk_i); #1;
      s_ack_i = 1'b0;
      #1;
    end
    n_cmp++; if (firsterr !== 2 * TO) begin n_err++; $display("FAIL at_restart: got err at %0d want %0d", firsterr, 2 * TO); end
    set_m(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  // Async reset during a granted write clears outputs before any clock edge
  task automatic test_reset_mid();
    int waited;
    set_m(1'b0, 1'b1, 1'b1, 16'h0600, 16'h6666);
    wait_grant(waited);
    s_ack_i = 1'b1;
    #1;
    n_cmp++; if (m_ack_o !== 2'b01 || s_cyc_o !== 1'b1) begin n_err++; $display("FAIL rm_pre: got ack%b cyc%b want 01 1", m_ack_o, s_cyc_o); end
    rst_i = 1'b1;
    #1;
    n_cmp++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || m_ack_o !== 2'b00)
      begin n_err++; $display("FAIL rm_async: got cyc%b g%b ack%b want 0 00 00", s_cyc_o, grant_o, m_ack_o); end
    s_ack_i = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rm_after: got %b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
